// File: rtl/capture_cmd_pkg.sv
// Shared constants for the LogicCaptureTop command arbiter: function codes,
// the ack bit position in status, and the transaction FSM state encoding.
package capture_cmd_pkg;

  localparam logic [7:0] CMD_NOP               = 8'h00;
  localparam logic [7:0] CMD_START             = 8'h01;
  localparam logic [7:0] CMD_ABORT             = 8'h02;
  localparam logic [7:0] CMD_TRIGGER_CONFIGURE = 8'h03;
  localparam logic [7:0] CMD_BUFFER_CONFIGURE  = 8'h04;
  localparam logic [7:0] CMD_READ_TRACE_DATA   = 8'h05;
  localparam logic [7:0] CMD_READ_TRACE_SIZE   = 8'h06;
  localparam logic [7:0] CMD_READ_TRIGGER_SAMP = 8'h07;
  localparam logic [7:0] CMD_ACK               = 8'h08;
  localparam logic [7:0] CMD_RESET             = 8'h09;

  localparam int ACK_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    ACK_STROBE,
    WAIT_CLR,
    DONE
  } state_t;

endpackage

// File: rtl/cmd_rr_arbiter.sv
// Two-way round-robin grant between requester A and B; the requester not
// granted last wins a tie. Last-grant resets to B so A wins the first tie.
module cmd_rr_arbiter (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic reqa,
  input  logic reqb,
  output logic gnta,
  output logic gntb
);

  logic last_b;

  always_comb begin
    gnta = 1'b0;
    gntb = 1'b0;
    if (en) begin
      if (reqa && reqb) begin
        gnta = last_b;
        gntb = !last_b;
      end else begin
        gnta = reqa;
        gntb = reqb;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last_b <= 1'b1;
    else if (gnta || gntb)
      last_b <= gntb;
  end

endmodule

// File: rtl/capture_cmd_arbiter.sv
// Arbitrates two command requesters onto the LogicCaptureTop command port and
// runs the strobe/ack handshake. Optional ack timeout: CMD_ARB_TIMEOUT_EN.
module capture_cmd_arbiter
  import capture_cmd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reqA,
  input  logic        reqB,
  input  logic [7:0]  cmdA,
  input  logic [7:0]  cmdB,
  input  logic [63:0] wdataA,
  input  logic [63:0] wdataB,
  output logic        doneA,
  output logic        doneB,
  output logic [63:0] rdata,
  output logic        err,
  output logic [7:0]  command,
  output logic        commandStrobe,
  output logic [7:0]  regIn0,
  output logic [7:0]  regIn1,
  output logic [7:0]  regIn2,
  output logic [7:0]  regIn3,
  output logic [7:0]  regIn4,
  output logic [7:0]  regIn5,
  output logic [7:0]  regIn6,
  output logic [7:0]  regIn7,
  input  logic [7:0]  regOut0,
  input  logic [7:0]  regOut1,
  input  logic [7:0]  regOut2,
  input  logic [7:0]  regOut3,
  input  logic [7:0]  regOut4,
  input  logic [7:0]  regOut5,
  input  logic [7:0]  regOut6,
  input  logic [7:0]  regOut7,
  input  logic [7:0]  status
);

  state_t      state_q, state_d;
  logic        gnt_a, gnt_b, granted_b;
  logic [7:0]  cmd_q, cmd_sel;
  logic [63:0] wdata_q, wdata_sel;
  logic        ack, timeout;
  logic        unused_status;

  assign ack           = status[ACK_BIT];
  assign unused_status = ^{status[7:ACK_BIT+1], status[ACK_BIT-1:0]};

  cmd_rr_arbiter u_rr (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_q == IDLE),
    .reqa   (reqA),
    .reqb   (reqB),
    .gnta   (gnt_a),
    .gntb   (gnt_b)
  );

  assign cmd_sel   = gnt_b ? cmdB : cmdA;
  assign wdata_sel = gnt_b ? wdataB : wdataA;

  // A NOP is completed at grant; an ack already present in ISSUE skips WAIT_ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (gnt_a || gnt_b) state_d = (cmd_sel == CMD_NOP) ? DONE : ISSUE;
      ISSUE:      state_d = ack ? ACK_STROBE : WAIT_ACK;
      WAIT_ACK: begin
        if (ack)          state_d = ACK_STROBE;
        else if (timeout) state_d = DONE;
      end
      ACK_STROBE: state_d = WAIT_CLR;
      WAIT_CLR:   if (!ack) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q     <= CMD_NOP;
      wdata_q   <= '0;
      rdata     <= '0;
      granted_b <= 1'b0;
    end else begin
      if (gnt_a || gnt_b) begin
        cmd_q     <= cmd_sel;
        wdata_q   <= wdata_sel;
        granted_b <= gnt_b;
      end
      if ((state_q == ISSUE || state_q == WAIT_ACK) && ack)
        rdata <= {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
    end
  end

  always_comb begin
    command       = CMD_NOP;
    commandStrobe = 1'b0;
    case (state_q)
      ISSUE: begin
        command       = cmd_q;
        commandStrobe = 1'b1;
      end
      WAIT_ACK:   command = cmd_q;
      ACK_STROBE: begin
        command       = CMD_ACK;
        commandStrobe = 1'b1;
      end
      WAIT_CLR:   command = CMD_ACK;
      default:    command = CMD_NOP;
    endcase
  end

  assign {regIn7, regIn6, regIn5, regIn4, regIn3, regIn2, regIn1, regIn0} = wdata_q;

  assign doneA = (state_q == DONE) && !granted_b;
  assign doneB = (state_q == DONE) && granted_b;

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == ISSUE)
        cnt_q <= '0;
      else if (state_q == WAIT_ACK)
        cnt_q <= cnt_q + 1'b1;
      if (gnt_a || gnt_b)
        to_q <= 1'b0;
      else if (state_q == WAIT_ACK && !ack && timeout)
        to_q <= 1'b1;
    end
  end

  assign err = (state_q == DONE) && to_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
